// File: rtl/tpulse_monitor.sv
// tpulse_monitor: monitor-side receiver for the timer time pulses.
// It synchronizes MT/MGOJAM/MSTP, decodes the one-hot T-pulse bus into an
// index, counts memory cycle times on each T12->T01 wrap, and latches the
// first ring-sequence fault for the debug logic. It never drives the timer.
// Optional feature macro: TPMON_STALL_EN (adds the pulse stall watchdog,
// fault code 3).
module tpulse_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_W     = 16,
  parameter int STALL_LIMIT = 64
) (
  input  logic               SIM_CLK,
  input  logic               SIM_RST,
  input  logic [11:0]        MT,
  input  logic               MGOJAM,
  input  logic               MSTP,
  input  logic               CLR_ERR,
  output logic [3:0]         TP_IDX,
  output logic               MCT_STB,
  output logic [COUNT_W-1:0] MCT_COUNT,
  output logic               ERR,
  output logic [1:0]         ERR_CODE,
  output logic [3:0]         ERR_IDX,
  output logic               TRACKING
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    RESYNC = 2'd2,
    FAULT  = 2'd3
  } state_e;

  localparam logic [1:0] CODE_MULTI = 2'd1;
  localparam logic [1:0] CODE_SKIP  = 2'd2;
  localparam logic [1:0] CODE_STALL = 2'd3;

  logic [11:0]            mt_sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] gojam_sync_q;
  logic [SYNC_STAGES-1:0] mstp_sync_q;

  logic [11:0] cur_s;
  logic        gojam_s;
  logic        mstp_s;
  logic        cur_onehot_s;
  logic        cur_multi_s;
  logic [3:0]  cur_idx_s;
  logic [3:0]  exp_idx_s;
  logic        stall_fault_s;

  state_e             state_q, state_d;
  logic [3:0]         last_idx_q, last_idx_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               stb_q, stb_d;
  logic               err_q, err_d;
  logic [1:0]         code_q, code_d;
  logic [3:0]         eidx_q, eidx_d;
  logic [3:0]         tp_idx_q;

  // Input synchronizer chains for the time-pulse bus and the control lines.
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        mt_sync_q[i] <= 12'd0;
      end
      gojam_sync_q <= '0;
      mstp_sync_q  <= '0;
    end else begin
      mt_sync_q[0]    <= MT;
      gojam_sync_q[0] <= MGOJAM;
      mstp_sync_q[0]  <= MSTP;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        mt_sync_q[i]    <= mt_sync_q[i-1];
        gojam_sync_q[i] <= gojam_sync_q[i-1];
        mstp_sync_q[i]  <= mstp_sync_q[i-1];
      end
    end
  end

  assign cur_s   = mt_sync_q[SYNC_STAGES-1];
  assign gojam_s = gojam_sync_q[SYNC_STAGES-1];
  assign mstp_s  = mstp_sync_q[SYNC_STAGES-1];

  // Classify the synchronized bus (zero/one/multi-hot) and encode the index.
  always_comb begin
    cur_onehot_s = (cur_s != 12'd0) && ((cur_s & (cur_s - 12'd1)) == 12'd0);
    cur_multi_s  = (cur_s != 12'd0) && !cur_onehot_s;
    cur_idx_s    = 4'd0;
    for (int i = 0; i < 12; i++) begin
      cur_idx_s = cur_s[i] ? 4'(i + 1) : cur_idx_s;
    end
    exp_idx_s = (last_idx_q == 4'd12) ? 4'd1 : (last_idx_q + 4'd1);
  end

`ifdef TPMON_STALL_EN
  localparam int STALL_W = $clog2(STALL_LIMIT + 2);
  localparam logic [STALL_W-1:0] STALL_SAT = STALL_W'(STALL_LIMIT + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);

  logic [STALL_W-1:0] stall_q, stall_d;

  // Stall counter: counts cycles the last pulse is held while tracking.
  always_comb begin
    stall_d = stall_q;
    if ((state_q != TRACK) || mstp_s ||
        (cur_onehot_s && (cur_idx_s != last_idx_q))) begin
      stall_d = '0;
    end else if (cur_onehot_s && (stall_q != STALL_SAT)) begin
      stall_d = stall_q + STALL_W'(1);
    end else begin
      stall_d = stall_q;
    end
    // Flag on the value about to be stored so the fault is raised as the
    // count passes the limit, not one cycle later.
    stall_fault_s = (state_q == TRACK) && (stall_d > STALL_MAX);
  end

  // Stall counter register.
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  // Stall checking compiled out: constant false for any legal limit.
  assign stall_fault_s = (STALL_LIMIT < 32'sd0);
`endif

  // Sequence checker FSM: next state, ring tracking, MCT count, fault latch.
  always_comb begin
    state_d    = state_q;
    last_idx_d = last_idx_q;
    count_d    = count_q;
    stb_d      = 1'b0;
    err_d      = err_q;
    code_d     = code_q;
    eidx_d     = eidx_q;
    case (state_q)
      IDLE: begin
        if (gojam_s) begin
          state_d = RESYNC;
        end else if (cur_onehot_s) begin
          last_idx_d = cur_idx_s;
          state_d    = TRACK;
        end else begin
          state_d = IDLE;
        end
      end
      TRACK: begin
        if (gojam_s) begin
          state_d = RESYNC;
        end else if (cur_multi_s) begin
          state_d = FAULT;
          err_d   = 1'b1;
          code_d  = CODE_MULTI;
          eidx_d  = last_idx_q;
        end else if (cur_onehot_s && (cur_idx_s != last_idx_q)) begin
          if (cur_idx_s == exp_idx_s) begin
            last_idx_d = cur_idx_s;
            if ((last_idx_q == 4'd12) && (cur_idx_s == 4'd1)) begin
              stb_d   = 1'b1;
              count_d = count_q + COUNT_W'(1);
            end else begin
              stb_d = 1'b0;
            end
          end else begin
            state_d = FAULT;
            err_d   = 1'b1;
            code_d  = CODE_SKIP;
            eidx_d  = last_idx_q;
          end
        end else if (stall_fault_s) begin
          state_d = FAULT;
          err_d   = 1'b1;
          code_d  = CODE_STALL;
          eidx_d  = last_idx_q;
        end else begin
          state_d = TRACK;
        end
      end
      RESYNC: begin
        if (gojam_s) begin
          state_d = RESYNC;
        end else if (cur_onehot_s) begin
          last_idx_d = cur_idx_s;
          state_d    = TRACK;
        end else begin
          state_d = RESYNC;
        end
      end
      FAULT: begin
        if (CLR_ERR) begin
          state_d = IDLE;
          err_d   = 1'b0;
          code_d  = 2'd0;
          eidx_d  = 4'd0;
          count_d = '0;
        end else begin
          state_d = FAULT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, tracking and fault registers.
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      state_q    <= IDLE;
      last_idx_q <= 4'd0;
      count_q    <= '0;
      stb_q      <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= 2'd0;
      eidx_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      last_idx_q <= last_idx_d;
      count_q    <= count_d;
      stb_q      <= stb_d;
      err_q      <= err_d;
      code_q     <= code_d;
      eidx_q     <= eidx_d;
    end
  end

  // Registered pulse-number decode; zero for zero-hot or multi-hot input.
  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      tp_idx_q <= 4'd0;
    end else begin
      tp_idx_q <= cur_onehot_s ? cur_idx_s : 4'd0;
    end
  end

  assign TP_IDX    = tp_idx_q;
  assign MCT_STB   = stb_q;
  assign MCT_COUNT = count_q;
  assign ERR       = err_q;
  assign ERR_CODE  = code_q;
  assign ERR_IDX   = eidx_q;
  assign TRACKING  = (state_q == TRACK);

endmodule

// File: tb/tb_tpulse_monitor.sv
// Directed bench for tpulse_monitor: ring counting, skip/multi-hot faults,
// MGOJAM resync, stall watchdog (build dependent) and async reset in FAULT.
module tb_tpulse_monitor;

  localparam int COUNT_W = 16;

  logic               SIM_CLK = 1'b0;
  logic               SIM_RST;
  logic [11:0]        MT;
  logic               MGOJAM;
  logic               MSTP;
  logic               CLR_ERR;
  logic [3:0]         TP_IDX;
  logic               MCT_STB;
  logic [COUNT_W-1:0] MCT_COUNT;
  logic               ERR;
  logic [1:0]         ERR_CODE;
  logic [3:0]         ERR_IDX;
  logic               TRACKING;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int stb_seen  = 0;
  int stb_base;

  tpulse_monitor #(
    .SYNC_STAGES(2),
    .COUNT_W    (COUNT_W),
    .STALL_LIMIT(64)
  ) dut (
    .SIM_CLK  (SIM_CLK),
    .SIM_RST  (SIM_RST),
    .MT       (MT),
    .MGOJAM   (MGOJAM),
    .MSTP     (MSTP),
    .CLR_ERR  (CLR_ERR),
    .TP_IDX   (TP_IDX),
    .MCT_STB  (MCT_STB),
    .MCT_COUNT(MCT_COUNT),
    .ERR      (ERR),
    .ERR_CODE (ERR_CODE),
    .ERR_IDX  (ERR_IDX),
    .TRACKING (TRACKING)
  );

  always #5 SIM_CLK = ~SIM_CLK;

  // Count strobe pulses seen on the output.
  always @(posedge SIM_CLK) begin
    if (MCT_STB === 1'b1) stb_seen <= stb_seen + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge SIM_CLK);
    #1;
  endtask

  function automatic logic [11:0] tp(input int n);
    logic [11:0] one;
    one = 12'd1;
    return one << (n - 1);
  endfunction

  task automatic pulse(input int n, input int cyc);
    MT = tp(n);
    tick(cyc);
  endtask

  task automatic clear_err();
    CLR_ERR = 1'b1;
    tick(1);
    CLR_ERR = 1'b0;
  endtask

  initial begin
    SIM_RST = 1'b0;
    MT      = 12'd0;
    MGOJAM  = 1'b0;
    MSTP    = 1'b0;
    CLR_ERR = 1'b0;
    tick(3);
    check_eq("rst_tp_idx",   32'(TP_IDX),    32'd0);
    check_eq("rst_mct_stb",  32'(MCT_STB),   32'd0);
    check_eq("rst_count",    32'(MCT_COUNT), 32'd0);
    check_eq("rst_err",      32'(ERR),       32'd0);
    check_eq("rst_err_code", 32'(ERR_CODE),  32'd0);
    check_eq("rst_err_idx",  32'(ERR_IDX),   32'd0);
    check_eq("rst_tracking", 32'(TRACKING),  32'd0);
    SIM_RST = 1'b1;
    tick(2);

    // Three full rings, 4 cycles per pulse.
    stb_base = stb_seen;
    for (int r = 0; r < 3; r++) begin
      for (int n = 1; n <= 12; n++) begin
        pulse(n, 4);
        if (r == 0 && n == 1) begin
          check_eq("ring_tracking_first", 32'(TRACKING), 32'd1);
          check_eq("ring_tp_idx_first",   32'(TP_IDX),   32'd1);
        end
      end
    end
    tick(5);
    check_eq("ring_count",  32'(MCT_COUNT),       32'd2);
    check_eq("ring_stb",    32'(stb_seen - stb_base), 32'd2);
    check_eq("ring_err",    32'(ERR),             32'd0);
    check_eq("ring_tp_idx", 32'(TP_IDX),          32'd12);

    // Skip T03 -> T05.
    pulse(1, 4);
    pulse(2, 4);
    pulse(3, 4);
    pulse(5, 4);
    tick(2);
    check_eq("skip_err",      32'(ERR),       32'd1);
    check_eq("skip_code",     32'(ERR_CODE),  32'd2);
    check_eq("skip_idx",      32'(ERR_IDX),   32'd3);
    check_eq("skip_count",    32'(MCT_COUNT), 32'd3);
    check_eq("skip_tracking", 32'(TRACKING),  32'd0);
    pulse(6, 4);
    pulse(12, 4);
    pulse(1, 4);
    check_eq("skip_count_frozen", 32'(MCT_COUNT), 32'd3);
    check_eq("skip_code_kept",    32'(ERR_CODE),  32'd2);
    MT = 12'd0;
    tick(4);
    clear_err();
    check_eq("clr_err",      32'(ERR),       32'd0);
    check_eq("clr_code",     32'(ERR_CODE),  32'd0);
    check_eq("clr_idx",      32'(ERR_IDX),   32'd0);
    check_eq("clr_count",    32'(MCT_COUNT), 32'd0);
    check_eq("clr_tracking", 32'(TRACKING),  32'd0);

    // Multi-hot for one cycle after T02.
    pulse(1, 4);
    pulse(2, 4);
    check_eq("multi_pre_tracking", 32'(TRACKING), 32'd1);
    MT = 12'h006;
    tick(1);
    MT = tp(2);
    tick(2);
    check_eq("multi_tp_idx", 32'(TP_IDX),   32'd0);
    check_eq("multi_err",    32'(ERR),      32'd1);
    check_eq("multi_code",   32'(ERR_CODE), 32'd1);
    check_eq("multi_idx",    32'(ERR_IDX),  32'd2);
    tick(1);
    check_eq("multi_tp_idx_back", 32'(TP_IDX), 32'd2);
    MT = 12'd0;
    tick(4);
    clear_err();
    check_eq("multi_clr_err", 32'(ERR), 32'd0);

    // MGOJAM while jumping T07 -> T12, release on T01.
    for (int n = 1; n <= 12; n++) pulse(n, 4);
    for (int n = 1; n <= 7; n++) pulse(n, 4);
    check_eq("gojam_pre_count", 32'(MCT_COUNT), 32'd1);
    MGOJAM = 1'b1;
    tick(2);
    MT = tp(12);
    tick(8);
    check_eq("gojam_tracking_low", 32'(TRACKING), 32'd0);
    MGOJAM = 1'b0;
    pulse(1, 4);
    pulse(2, 4);
    pulse(3, 4);
    check_eq("gojam_err",      32'(ERR),       32'd0);
    check_eq("gojam_tracking", 32'(TRACKING),  32'd1);
    check_eq("gojam_count",    32'(MCT_COUNT), 32'd1);

    // Long hold with MSTP=1: never a fault.
    MSTP = 1'b1;
    tick(4);
    pulse(4, 100);
    check_eq("mstp_hold_err",      32'(ERR),      32'd0);
    check_eq("mstp_hold_tracking", 32'(TRACKING), 32'd1);

    // Long hold with MSTP=0.
    MSTP = 1'b0;
    pulse(5, 75);
`ifdef TPMON_STALL_EN
    check_eq("stall_err",  32'(ERR),      32'd1);
    check_eq("stall_code", 32'(ERR_CODE), 32'd3);
    check_eq("stall_idx",  32'(ERR_IDX),  32'd5);
`else
    check_eq("nostall_err",      32'(ERR),      32'd0);
    check_eq("nostall_tracking", 32'(TRACKING), 32'd1);
`endif

    // Force or keep FAULT with a skip, then async reset.
    pulse(7, 6);
    check_eq("fault_err", 32'(ERR), 32'd1);
`ifdef TPMON_STALL_EN
    check_eq("fault_first_wins", 32'(ERR_CODE), 32'd3);
`else
    check_eq("fault_skip_code", 32'(ERR_CODE), 32'd2);
`endif
    check_eq("fault_idx", 32'(ERR_IDX), 32'd5);
    SIM_RST = 1'b0;
    #1;
    check_eq("arst_err",      32'(ERR),       32'd0);
    check_eq("arst_code",     32'(ERR_CODE),  32'd0);
    check_eq("arst_idx",      32'(ERR_IDX),   32'd0);
    check_eq("arst_count",    32'(MCT_COUNT), 32'd0);
    check_eq("arst_tp_idx",   32'(TP_IDX),    32'd0);
    check_eq("arst_stb",      32'(MCT_STB),   32'd0);
    check_eq("arst_tracking", 32'(TRACKING),  32'd0);
    MT = 12'd0;
    tick(3);
    SIM_RST = 1'b1;
    tick(4);
    check_eq("post_rst_tracking", 32'(TRACKING), 32'd0);
    pulse(1, 4);
    pulse(2, 4);
    check_eq("post_rst_track", 32'(TRACKING),  32'd1);
    check_eq("post_rst_count", 32'(MCT_COUNT), 32'd0);
    check_eq("post_rst_err",   32'(ERR),       32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/tpulse_monitor.md
Name: tpulse_monitor

Overview:
- Monitor-side receiver for the timer's time-pulse outputs (MT01..MT12, MGOJAM, MSTP).
- Decodes the one-hot T-pulse bus into an index and counts memory cycle times (MCTs).
- Checks the T01→T12 ring sequence and latches the first sequence fault for the monitor/debug logic.
- Sits on the monitor side of the timer interface and never drives the timer.

Parameters:
- SYNC_STAGES, 2: input synchronizer depth (1..3) on MT, MGOJAM, MSTP.
- COUNT_W, 16: width of the MCT counter.
- STALL_LIMIT, 64: maximum consecutive cycles one pulse may be held before a stall fault (only with TPMON_STALL_EN).

Ports:
- SIM_CLK  input  1  sole clock.
- SIM_RST  input  1  asynchronous, active-low reset.
- MT  input  12  time pulses; bit0=MT01 … bit11=MT12.
- MGOJAM  input  1  monitor copy of GOJAM.
- MSTP  input  1  monitor stop request; suppresses the stall check.
- CLR_ERR  input  1  synchronous clear of the fault latch.
- TP_IDX  output  4  current pulse number 1..12; 0 = none or invalid.
- MCT_STB  output  1  one-cycle pulse on each valid T12→T01 wrap.
- MCT_COUNT  output  COUNT_W  MCTs since reset or clear.
- ERR  output  1  sticky fault flag.
- ERR_CODE  output  2  first fault type: 0 none, 1 multi-hot, 2 skip, 3 stall.
- ERR_IDX  output  4  last valid index at the time of the fault.
- TRACKING  output  1  high in TRACK state.

Behaviour:
- Reset values:
  - All outputs 0.
  - Synchronizer flops 0, last_idx 0, stall counter 0.
  - State IDLE.
- Inputs pass through SYNC_STAGES flops; cur denotes the synchronized MT.
- TP_IDX:
  - Registered decode of cur.
  - Latency SYNC_STAGES+1 cycles from an MT change.
  - 0 when cur is zero-hot or multi-hot.
- One-hot valid pulse: cur has exactly one bit set; idx = bit position + 1.
- A transition is a valid pulse with idx != last_idx.
- States:
  - IDLE: no checking. The first valid pulse loads last_idx and moves to TRACK.
  - TRACK:
    - On a transition, expected = last_idx+1, with 12 wrapping to 1.
    - If idx == expected: last_idx updates. If last_idx was 12 and idx is 1, MCT_STB=1 and MCT_COUNT increments (wraps at 2^COUNT_W).
    - If idx != expected: fault code 2.
    - Multi-hot cur in any cycle: fault code 1.
    - Zero-hot cur: no fault, no update.
  - RESYNC:
    - Entered from IDLE or TRACK whenever synced MGOJAM=1. Held while MGOJAM=1, with all checks suppressed.
    - After MGOJAM falls, the first valid pulse loads last_idx without a check and returns to TRACK.
    - Normal release is T12→T01, which does not count as an MCT.
  - FAULT:
    - Entered on any fault. On entry, ERR=1, ERR_CODE and ERR_IDX (= last_idx) are latched, registered one cycle after detection.
    - TP_IDX keeps decoding. No MCT counting. No further fault capture: the first fault wins.
    - CLR_ERR=1 clears ERR, ERR_CODE, ERR_IDX and MCT_COUNT, and goes to IDLE.
- Priority within one cycle:
  - MGOJAM over fault detection.
  - Multi-hot over skip.
  - A fault detected in the same cycle as CLR_ERR (state not FAULT) is captured; CLR_ERR is ignored outside FAULT.
- TRACKING = (state == TRACK).
- Async reset mid-operation returns everything to reset values immediately; no MCT is counted on release.

Optional Feature:
- Macro TPMON_STALL_EN.
- When defined:
  - A stall counter increments each cycle in TRACK while cur equals the last valid pulse and synced MSTP=0.
  - The counter clears on any transition, on MSTP=1, or outside TRACK.
  - When the counter exceeds STALL_LIMIT, fault code 3 is raised.
  - The counter saturates at STALL_LIMIT+1.
- When undefined: no counter logic, and code 3 is never produced.

Test Plan:
- Reset release; drive MT01..MT12 rotating, 4 cycles each, for 3 rings → TRACKING=1 after the first pulse; MCT_COUNT=2 (first ring entered mid-IDLE); 2 MCT_STB pulses; ERR=0.
- Skip: sequence T03→T05 in TRACK → ERR=1, ERR_CODE=2, ERR_IDX=3; MCT_COUNT frozen; CLR_ERR → ERR=0, MCT_COUNT=0, state IDLE.
- Multi-hot: MT=12'h006 for 1 cycle → ERR_CODE=1, ERR_IDX=last valid index, TP_IDX=0 during that cycle(+latency).
- MGOJAM: high for 10 cycles while MT jumps T07→T12, then release and T01 → no fault; TRACKING resumes; MCT_COUNT unchanged.
- With TPMON_STALL_EN and STALL_LIMIT=64: hold T04 for 66 cycles, MSTP=0 → ERR_CODE=3. Repeat with MSTP=1 → no fault.
- Async reset asserted in FAULT state → all outputs 0 within the same cycle; IDLE after release.
